// File: rtl/ex_m_elastic_reg_pkg.sv
// Shared types for the EX/MEM elastic register: occupancy state encoding and
// the default channel layout of the packed data bus.
package ex_m_elastic_reg_pkg;

    // Encoding doubles as the occupancy count driven on o_occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int CH_PC8   = 0;
    localparam int CH_ALU   = 1;
    localparam int CH_WDATA = 2;
    localparam int CH_DADDR = 3;

endpackage

// File: rtl/ex_m_elastic_reg_if.sv
// Valid/ready channel carrying packed data channels plus a control word.
interface ex_m_elastic_reg_if #(
    parameter int NB_REG  = 32,
    parameter int N_CH    = 4,
    parameter int NB_CTRL = 9
);
    logic                     valid;
    logic                     ready;
    logic [N_CH*NB_REG-1:0]   data;
    logic [NB_CTRL-1:0]       ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/ex_m_elastic_reg_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones until reset.
module sat_counter #(
    parameter int NB_CNT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    output logic [NB_CNT-1:0] o_count
);
    logic [NB_CNT-1:0] cnt_q;
    logic [NB_CNT-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_en && (cnt_q != {NB_CNT{1'b1}})) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;
endmodule

// File: rtl/ex_m_elastic_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer, flush, debug freeze,
// debug channel readout and a saturating back-pressure counter.
module ex_m_elastic_reg
    import ex_m_elastic_reg_pkg::*;
#(
    parameter int NB_REG  = 32,
    parameter int N_CH    = 4,
    parameter int NB_CTRL = 9,
    parameter int NB_SEL  = 2,
    parameter int NB_CNT  = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_dunit_clk_en,
    input  logic                i_flush,
    ex_m_elastic_reg_if.slave   s_ex,
    ex_m_elastic_reg_if.master  m_mem,
    input  logic [NB_SEL-1:0]   i_dbg_sel,
    output logic [NB_REG-1:0]   o_dbg_data,
    output logic [NB_CNT-1:0]   o_stall_cnt,
    output logic [1:0]          o_occupancy
);
    localparam int NB_DATA = N_CH * NB_REG;
    localparam int N_SLOT  = 1 << NB_SEL;

    state_t               state_q, state_d;
    logic [NB_DATA-1:0]   head_data_q, head_data_d;
    logic [NB_DATA-1:0]   skid_data_q, skid_data_d;
    logic [NB_CTRL-1:0]   head_ctrl_q, head_ctrl_d;
    logic [NB_CTRL-1:0]   skid_ctrl_q, skid_ctrl_d;

    logic head_valid;
    logic skid_valid;
    logic in_fire;
    logic out_fire;
    logic stall;

    // Handshake outputs come only from registered state, so no combinational
    // path exists from i_ready/i_valid back to o_ready/o_valid.
    assign head_valid  = (state_q != EMPTY);
    assign skid_valid  = (state_q == TWO);
    assign s_ex.ready  = i_dunit_clk_en & ~skid_valid;
    assign m_mem.valid = i_dunit_clk_en & head_valid;
    assign m_mem.data  = head_data_q;
    assign m_mem.ctrl  = m_mem.valid ? head_ctrl_q : '0;
    assign o_occupancy = state_q;

    assign in_fire  = s_ex.valid & s_ex.ready;
    assign out_fire = m_mem.valid & m_mem.ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (i_dunit_clk_en) begin
            if (i_flush) begin
                // Bubble: control words zeroed, data left as-is.
                state_d     = EMPTY;
                head_ctrl_d = '0;
                skid_ctrl_d = '0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            state_d     = ONE;
                            head_data_d = s_ex.data;
                            head_ctrl_d = s_ex.ctrl;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            head_data_d = s_ex.data;
                            head_ctrl_d = s_ex.ctrl;
                        end else if (in_fire) begin
                            state_d     = TWO;
                            skid_data_d = s_ex.data;
                            skid_ctrl_d = s_ex.ctrl;
                        end else if (out_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    TWO: begin
                        if (out_fire) begin
                            state_d     = ONE;
                            head_data_d = skid_data_q;
                            head_ctrl_d = skid_ctrl_q;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= EMPTY;
            head_data_q <= '0;
            head_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    // m_mem.valid already drops during freeze, so the count holds too.
    assign stall = m_mem.valid & ~m_mem.ready;

    sat_counter #(
        .NB_CNT (NB_CNT)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (stall),
        .o_count (o_stall_cnt)
    );

    // Select slots beyond N_CH read as zero.
    logic [NB_REG-1:0] dbg_slot [N_SLOT];

    generate
        for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_dbg
            if (gi < N_CH) begin : g_ch
                assign dbg_slot[gi] = head_data_q[gi*NB_REG +: NB_REG];
            end else begin : g_pad
                assign dbg_slot[gi] = '0;
            end
        end
    endgenerate

    assign o_dbg_data = dbg_slot[i_dbg_sel];
endmodule

// File: tb/tb_ex_m_elastic_reg.sv
// Directed bench for ex_m_elastic_reg: a default instance and a reduced
// instance (3 channels, 4-bit counter) driven from one linear sequence.
module tb_ex_m_elastic_reg;
    import ex_m_elastic_reg_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic flush;
    logic [1:0]  dbg_sel_a, dbg_sel_b;
    logic [31:0] dbg_a, dbg_b;
    logic [15:0] stall_a;
    logic [3:0]  stall_b;
    logic [1:0]  occ_a, occ_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_m_elastic_reg_if #(.NB_REG(32), .N_CH(4), .NB_CTRL(9)) a_in ();
    ex_m_elastic_reg_if #(.NB_REG(32), .N_CH(4), .NB_CTRL(9)) a_out ();
    ex_m_elastic_reg_if #(.NB_REG(32), .N_CH(3), .NB_CTRL(9)) b_in ();
    ex_m_elastic_reg_if #(.NB_REG(32), .N_CH(3), .NB_CTRL(9)) b_out ();

    ex_m_elastic_reg #(
        .NB_REG(32), .N_CH(4), .NB_CTRL(9), .NB_SEL(2), .NB_CNT(16)
    ) dut_a (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_dunit_clk_en (en),
        .i_flush        (flush),
        .s_ex           (a_in),
        .m_mem          (a_out),
        .i_dbg_sel      (dbg_sel_a),
        .o_dbg_data     (dbg_a),
        .o_stall_cnt    (stall_a),
        .o_occupancy    (occ_a)
    );

    ex_m_elastic_reg #(
        .NB_REG(32), .N_CH(3), .NB_CTRL(9), .NB_SEL(2), .NB_CNT(4)
    ) dut_b (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_dunit_clk_en (en),
        .i_flush        (flush),
        .s_ex           (b_in),
        .m_mem          (b_out),
        .i_dbg_sel      (dbg_sel_b),
        .o_dbg_data     (dbg_b),
        .o_stall_cnt    (stall_b),
        .o_occupancy    (occ_b)
    );

    function automatic logic [127:0] mk4(input logic [31:0] c0, input logic [31:0] c1,
                                         input logic [31:0] c2, input logic [31:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; flush = 1'b0;
        a_in.valid = 1'b0; a_in.data = '0; a_in.ctrl = '0; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.data = '0; b_in.ctrl = '0; b_out.ready = 1'b0;
        dbg_sel_a = 2'd0; dbg_sel_b = 2'd0;
        tick(); tick();

        $display("step reset");
        chk("rst_valid", a_out.valid, 0);
        chk("rst_ctrl",  a_out.ctrl, 0);
        chk("rst_data",  a_out.data, 0);
        chk("rst_dbg",   dbg_a, 0);
        chk("rst_occ",   occ_a, 0);
        chk("rst_ready", a_in.ready, 1);
        chk("rst_stall", stall_a, 0);
        rst_n = 1'b1;
        tick();

        $display("step first entry");
        a_in.valid = 1'b1; a_in.data = mk4(32'h0, 32'h0000_00AA, 32'h0, 32'h0);
        a_in.ctrl = 9'h1FF; a_out.ready = 1'b1;
        tick();
        chk("first_valid", a_out.valid, 1);
        chk("first_ch1",   a_out.data[CH_ALU*32 +: 32], 32'h0000_00AA);
        chk("first_ctrl",  a_out.ctrl, 9'h1FF);
        chk("first_occ",   occ_a, 1);

        $display("step pass-through in+out");
        a_in.data = mk4(32'h0, 32'h0000_00BB, 32'h0, 32'h0); a_in.ctrl = 9'h055;
        tick();
        chk("pass_occ",  occ_a, 1);
        chk("pass_ch1",  a_out.data[CH_ALU*32 +: 32], 32'h0000_00BB);
        chk("pass_ctrl", a_out.ctrl, 9'h055);
        a_in.valid = 1'b0;
        tick();
        chk("drain_occ",   occ_a, 0);
        chk("drain_valid", a_out.valid, 0);
        chk("drain_ctrl",  a_out.ctrl, 0);

        $display("step backpressure A,B");
        a_out.ready = 1'b0; a_in.valid = 1'b1;
        a_in.data = mk4(32'hA0, 32'hA1, 32'hA2, 32'hA3); a_in.ctrl = 9'h0A1;
        tick();
        a_in.data = mk4(32'hB0, 32'hB1, 32'hB2, 32'hB3); a_in.ctrl = 9'h0B2;
        tick();
        a_in.valid = 1'b0;
        tick();
        chk("bp_occ",   occ_a, 2);
        chk("bp_ready", a_in.ready, 0);
        chk("bp_headA", a_out.data, mk4(32'hA0, 32'hA1, 32'hA2, 32'hA3));
        chk("bp_ctrlA", a_out.ctrl, 9'h0A1);
        chk("bp_stall", stall_a, 2);
        a_out.ready = 1'b1;
        tick();
        chk("ord_headB", a_out.data, mk4(32'hB0, 32'hB1, 32'hB2, 32'hB3));
        chk("ord_ctrlB", a_out.ctrl, 9'h0B2);
        chk("ord_occ1",  occ_a, 1);
        tick();
        chk("ord_occ0",  occ_a, 0);
        chk("ord_stall", stall_a, 2);

        $display("step flush at occupancy 2");
        a_out.ready = 1'b0; a_in.valid = 1'b1;
        a_in.data = mk4(32'hD0, 32'hD1, 32'hD2, 32'hD3); a_in.ctrl = 9'h0D1;
        tick();
        a_in.data = mk4(32'hE0, 32'hE1, 32'hE2, 32'hE3); a_in.ctrl = 9'h0E1;
        tick();
        flush = 1'b1;
        a_in.data = mk4(32'hC0, 32'hC1, 32'hC2, 32'hC3); a_in.ctrl = 9'h0C1;
        tick();
        chk("fl2_valid", a_out.valid, 0);
        chk("fl2_ctrl",  a_out.ctrl, 0);
        chk("fl2_occ",   occ_a, 0);
        chk("fl2_data",  a_out.data, mk4(32'hD0, 32'hD1, 32'hD2, 32'hD3));

        $display("step flush at occupancy 1");
        flush = 1'b0;
        a_in.data = mk4(32'hF0, 32'hF1, 32'hF2, 32'hF3); a_in.ctrl = 9'h0F1;
        tick();
        flush = 1'b1;
        a_in.data = mk4(32'hC0, 32'hC1, 32'hC2, 32'hC3); a_in.ctrl = 9'h0C1;
        tick();
        chk("fl1_occ",   occ_a, 0);
        chk("fl1_valid", a_out.valid, 0);
        chk("fl1_data",  a_out.data, mk4(32'hF0, 32'hF1, 32'hF2, 32'hF3));
        flush = 1'b0; a_in.valid = 1'b0; a_out.ready = 1'b1;
        tick();
        chk("fl_idle_occ", occ_a, 0);
        chk("fl_stall",    stall_a, 5);

        $display("step freeze");
        a_out.ready = 1'b0; a_in.valid = 1'b1;
        a_in.data = mk4(32'h60, 32'h61, 32'h62, 32'h63); a_in.ctrl = 9'h0A5;
        tick();
        en = 1'b0; flush = 1'b1; a_out.ready = 1'b1;
        a_in.data = mk4(32'h70, 32'h71, 32'h72, 32'h73); a_in.ctrl = 9'h0C3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz_valid", a_out.valid, 0);
            chk("frz_ready", a_in.ready, 0);
            chk("frz_occ",   occ_a, 1);
            chk("frz_stall", stall_a, 5);
        end
        en = 1'b1; flush = 1'b0; a_in.valid = 1'b0; a_out.ready = 1'b0;
        #1;
        chk("rsm_valid", a_out.valid, 1);
        chk("rsm_data",  a_out.data, mk4(32'h60, 32'h61, 32'h62, 32'h63));
        chk("rsm_ctrl",  a_out.ctrl, 9'h0A5);
        chk("rsm_ready", a_in.ready, 1);
        tick();
        chk("rsm_stall", stall_a, 6);
        a_out.ready = 1'b1;
        tick();
        chk("rsm_drain", occ_a, 0);

        $display("step debug readout");
        a_out.ready = 1'b0; a_in.valid = 1'b1;
        a_in.data = mk4(32'h0000_0008, 32'h0000_0001, 32'h0000_0002, 32'h1000_0040);
        a_in.ctrl = 9'h003;
        tick();
        a_in.valid = 1'b0;
        dbg_sel_a = 2'(CH_DADDR);
        #1;
        chk("dbg_sel3", dbg_a, 32'h1000_0040);
        dbg_sel_a = 2'(CH_ALU);
        #1;
        chk("dbg_sel1", dbg_a, 32'h0000_0001);
        a_out.ready = 1'b1;
        tick();

        $display("step reduced instance");
        b_in.valid = 1'b1; b_in.data = {32'h3C, 32'h2B, 32'h1A}; b_in.ctrl = 9'h001;
        tick();
        b_in.valid = 1'b0;
        dbg_sel_b = 2'd3;
        #1;
        chk("b_dbg3", dbg_b, 0);
        dbg_sel_b = 2'd2;
        #1;
        chk("b_dbg2", dbg_b, 32'h3C);
        repeat (14) tick();
        chk("b_stall14", stall_b, 14);
        repeat (6) tick();
        chk("b_stall_sat", stall_b, 15);
        chk("b_occ", occ_b, 1);

        $display("step reset mid-transfer");
        a_out.ready = 1'b0; a_in.valid = 1'b1;
        a_in.data = mk4(32'h90, 32'h91, 32'h92, 32'h93); a_in.ctrl = 9'h091;
        tick(); tick();
        chk("pre_rst_occ", occ_a, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_occ",   occ_a, 0);
        chk("mid_rst_valid", a_out.valid, 0);
        chk("mid_rst_stall", stall_a, 0);
        chk("mid_rst_bstl",  stall_b, 0);
        chk("mid_rst_bocc",  occ_b, 0);
        a_in.valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_occ", occ_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_m_elastic_reg.md
Name: ex_m_elastic_reg

Overview:
Parametrised successor of the fixed EX/MEM pipeline register. It carries N_CH packed data channels and one control word from EX to MEM behind a valid/ready handshake. A 2-entry skid buffer lets MEM back-pressure EX without a combinational ready path. It adds synchronous flush (bubble insertion), a debug-unit freeze, a debug channel readout and a saturating stall counter.

Parameters:
NB_REG, 32, width of one data channel
N_CH, 4, number of data channels (default order: ch0 pc+8, ch1 alu result, ch2 write data, ch3 data address)
NB_CTRL, 9, control word width
NB_SEL, 2, debug channel-select width (must satisfy 2^NB_SEL >= N_CH)
NB_CNT, 16, stall counter width

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_dunit_clk_en  in  1  debug-unit enable; 0 freezes the block
i_flush  in  1  synchronous flush of all held entries
i_valid  in  1  EX presents an entry
o_ready  out  1  block can accept an entry
i_data  in  N_CH*NB_REG  packed channels; channel k occupies bits [k*NB_REG +: NB_REG]
i_ctrl  in  NB_CTRL  control word from EX
o_valid  out  1  head entry valid toward MEM
i_ready  in  1  MEM accepts the head entry
o_data  out  N_CH*NB_REG  head entry data
o_ctrl  out  NB_CTRL  head entry control; forced to 0 when o_valid=0
i_dbg_sel  in  NB_SEL  debug channel select
o_dbg_data  out  NB_REG  head-register channel i_dbg_sel; 0 if i_dbg_sel >= N_CH
o_stall_cnt  out  NB_CNT  saturating count of back-pressured cycles
o_occupancy  out  2  number of held entries (0, 1 or 2)

Behaviour:
- Reset (i_reset=0, asynchronous): head and skid registers cleared, both valid bits 0, counter 0. o_valid=0, o_ctrl=0, o_data=0, o_dbg_data=0, o_occupancy=0. o_ready=1 once the block is enabled.
- Storage: head register drives the outputs; skid register holds a second entry. States: EMPTY (occupancy 0), ONE (head valid), TWO (head and skid valid).
- o_ready = i_dunit_clk_en & ~skid_valid. o_valid = i_dunit_clk_en & head_valid. Both are registered-state-derived; neither depends combinationally on i_ready or i_valid.
- Fire signals: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- EMPTY: in_fire -> ONE, head <= input.
- ONE, in_fire & out_fire -> ONE, head <= input.
- ONE, in_fire only -> TWO, skid <= input.
- ONE, out_fire only -> EMPTY.
- TWO: o_ready=0. out_fire -> ONE, head <= skid.
- Latency: 1 cycle from in_fire to o_valid when EMPTY. No entry is ever dropped or duplicated.
- Flush (i_flush=1 while enabled): next state EMPTY, head and skid control words <= 0. Data registers keep their values. Flush overrides a simultaneous in_fire; the input entry is discarded. Any out_fire in the same cycle still completes.
- Freeze (i_dunit_clk_en=0): no register changes, including the counter. o_valid=0 and o_ready=0, so no handshake occurs. i_flush is ignored. State resumes unchanged when the enable returns to 1.
- Stall counter: increments when o_valid & ~i_ready. It saturates at 2^NB_CNT-1 and is cleared only by reset.
- o_dbg_data is combinational from the head register, regardless of valid or freeze.
- Reset asserted mid-transfer: all entries are lost and the block returns to EMPTY immediately.

Decomposition:
- Shared package: state encodings EMPTY, ONE and TWO. Default channel-index constants CH_PC8=0, CH_ALU=1, CH_WDATA=2, CH_DADDR=3.
- One sub-module: sat_counter (width NB_CNT, enable input, asynchronous active-low reset), reusable by other stages for stall statistics.

Test Plan:
- Reset, then i_valid=1 with ch1=0x0000_00AA, ctrl=0x1FF, i_ready=1 -> next cycle o_valid=1, ch1 reads 0x0000_00AA, o_ctrl=0x1FF, o_occupancy=1.
- i_ready=0, push entries A then B -> o_occupancy=2 and o_ready=0; head is A. Raise i_ready -> A, then B, delivered in order; o_stall_cnt=2.
- Occupancy 2 with i_flush=1 and i_valid=1 (entry C) -> next cycle o_valid=0, o_ctrl=0, o_occupancy=0; C never appears on the output.
- Occupancy 1, i_dunit_clk_en=0 for 5 cycles with i_valid=i_ready=1 -> o_valid=o_ready=0 and no state or counter change; on re-enable the head entry appears unchanged.
- i_dbg_sel=3 with head ch3=0x1000_0040 -> o_dbg_data=0x1000_0040. With N_CH=3 and i_dbg_sel=3 -> o_dbg_data=0.
- NB_CNT=4, i_ready held 0 for 20 cycles with head valid -> o_stall_cnt stops at 15.
